// File: rtl/vga_src_sched.sv
// vga_src_sched: frame-synchronous scheduler for the shared VGA pixel path.
// Latches per-source requests only on frame_start, so the granted source can
// change only between frames. The granted source's pixel is muxed onto
// data_out with one cycle of registered latency.
//
// Optional feature: define VGA_SRC_SCHED_RR_EN to replace fixed-priority
// winner selection (lowest requesting index) with round-robin selection
// starting just after the last granted index.
//
// state     | meaning
// ----------+--------------------------------------------
// ST_IDLE   | no source granted, data_out blanks
// ST_ACTIVE | exactly one source granted (src_sel valid)

module vga_src_sched #(
    parameter int                N_SRC       = 4,
    parameter int                DATA_W      = 16,
    parameter int                MIN_FRAMES  = 2,
    parameter logic [DATA_W-1:0] BLANK_COLOR = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_start,
    input  logic                      de,
    input  logic [N_SRC-1:0]          src_req,
    input  logic [N_SRC*DATA_W-1:0]   src_data,
    output logic [N_SRC-1:0]          src_grant,
    output logic [$clog2(N_SRC)-1:0]  src_sel,
    output logic                      sel_valid,
    output logic                      switch_pulse,
    output logic [DATA_W-1:0]         data_out
);

    localparam int SEL_W  = $clog2(N_SRC);
    localparam int HOLD_W = $clog2(MIN_FRAMES + 1);

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_FRAMES);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    logic [0:0]        state;
    logic [0:0]        nxt_state;
    logic [SEL_W-1:0]  nxt_sel;
    logic              nxt_change;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] nxt_hold;

    logic              win_found;
    logic [SEL_W-1:0]  win_idx;

    logic [DATA_W-1:0] src_pix [N_SRC];

`ifdef VGA_SRC_SCHED_RR_EN
    logic [SEL_W-1:0]  rr_ptr;
`endif

    // Unpack the flat source bus into one pixel per source.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            src_pix[i] = src_data[i*DATA_W +: DATA_W];
        end
    end

    // Winner selection among the current requesters.
    always_comb begin
        win_found = |src_req;
        win_idx   = '0;
`ifdef VGA_SRC_SCHED_RR_EN
        // Walk from the farthest candidate back to the nearest so the
        // first requester after rr_ptr is the last one assigned; rr_ptr
        // itself is considered last (k == N_SRC).
        for (int k = N_SRC; k >= 1; k--) begin
            int j;
            j = int'(rr_ptr) + k;
            if (j >= N_SRC) begin
                j = j - N_SRC;
            end
            if (src_req[j]) begin
                win_idx = SEL_W'(j);
            end
        end
`else
        // Scan downward so the lowest requesting index wins.
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (src_req[i]) begin
                win_idx = SEL_W'(i);
            end
        end
`endif
    end

    // Frame-boundary grant decision; outside frame_start nothing moves.
    always_comb begin
        nxt_state  = state;
        nxt_sel    = src_sel;
        nxt_change = 1'b0;
        nxt_hold   = hold_cnt;

        if (frame_start) begin
            if (!win_found) begin
                nxt_state  = ST_IDLE;
                nxt_sel    = '0;
                nxt_hold   = '0;
                nxt_change = (state == ST_ACTIVE);
            end else if (state == ST_IDLE) begin
                nxt_state  = ST_ACTIVE;
                nxt_sel    = win_idx;
                nxt_hold   = '0;
                nxt_change = 1'b1;
            end else if (!src_req[src_sel]) begin
                // Current owner dropped out; some other source wins.
                nxt_sel    = win_idx;
                nxt_hold   = '0;
                nxt_change = 1'b1;
            end else if (int'(hold_cnt) < MIN_FRAMES - 1) begin
                // Owner still inside its minimum tenure.
                nxt_hold = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
            end else if (win_idx == src_sel) begin
                // Re-arbitration picked the owner again: no visible change.
                nxt_hold = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
            end else begin
                nxt_sel    = win_idx;
                nxt_hold   = '0;
                nxt_change = 1'b1;
            end
        end
    end

    // Registered grant outputs and FSM state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            src_sel      <= '0;
            sel_valid    <= 1'b0;
            src_grant    <= '0;
            switch_pulse <= 1'b0;
        end else begin
            state        <= nxt_state;
            src_sel      <= nxt_sel;
            sel_valid    <= (nxt_state == ST_ACTIVE);
            src_grant    <= (nxt_state == ST_ACTIVE)
                            ? ({{(N_SRC-1){1'b0}}, 1'b1} << nxt_sel)
                            : '0;
            switch_pulse <= nxt_change;
        end
    end

    // Tenure counter: frames the current owner has held the grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= nxt_hold;
        end
    end

`ifdef VGA_SRC_SCHED_RR_EN
    // Remember the most recently granted index as the round-robin origin.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (frame_start && (nxt_state == ST_ACTIVE)) begin
            rr_ptr <= nxt_sel;
        end
    end
`endif

    // Pixel mux; de is used as-is, so the caller aligns it with the latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= BLANK_COLOR;
        end else if (sel_valid && de) begin
            data_out <= src_pix[src_sel];
        end else begin
            data_out <= BLANK_COLOR;
        end
    end

endmodule
